// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared mode constants, sync polarity constants and flag bundle for the raster timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_timing_pkg;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // 640x480@60 (25.175 MHz pixel clock), negative syncs
  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FP     = 16;
  localparam int M640_H_SYNC   = 96;
  localparam int M640_H_BP     = 48;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FP     = 10;
  localparam int M640_V_SYNC   = 2;
  localparam int M640_V_BP     = 33;
  localparam bit M640_H_POL    = POL_ACTIVE_LOW;
  localparam bit M640_V_POL    = POL_ACTIVE_LOW;

  // 800x600@60 (40 MHz pixel clock), positive syncs
  localparam int M800_H_ACTIVE = 800;
  localparam int M800_H_FP     = 40;
  localparam int M800_H_SYNC   = 128;
  localparam int M800_H_BP     = 88;
  localparam int M800_V_ACTIVE = 600;
  localparam int M800_V_FP     = 1;
  localparam int M800_V_SYNC   = 4;
  localparam int M800_V_BP     = 23;
  localparam bit M800_H_POL    = POL_ACTIVE_HIGH;
  localparam bit M800_V_POL    = POL_ACTIVE_HIGH;

  // Decoded per-position flags, kept in active-high form until the output stage.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic ls;
    logic fs;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, ls: 1'b0, fs: 1'b0};

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_delay_line.sv
// delay_line: ce-gated shift register of DEPTH stages, DEPTH=0 is a wire.
// Latency: DEPTH ce-advances. Ports: clk, rst (async active-low), ce, d[WIDTH], q[WIDTH].
// Backpressure: none; ce=0 freezes every stage.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, ce};
    assign q = d;
  end else begin : g_stages
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else if (ce) begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing.sv
// video_timing: parametrised raster generator; x/y counters plus sync/blank/de/line_start/frame_start flags.
// Latency: flags for position P appear PIPE_DELAY ce-steps after x/y show P (all outputs registered).
// Backpressure: none; ce=0 holds every register. Ports: clk, rst (async low), ce in; x, y, h_sync, v_sync, blanking, de, line_start, frame_start out.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = M640_H_ACTIVE,
  parameter int H_FP       = M640_H_FP,
  parameter int H_SYNC     = M640_H_SYNC,
  parameter int H_BP       = M640_H_BP,
  parameter int V_ACTIVE   = M640_V_ACTIVE,
  parameter int V_FP       = M640_V_FP,
  parameter int V_SYNC     = M640_V_SYNC,
  parameter int V_BP       = M640_V_BP,
  parameter bit H_POL      = M640_H_POL,
  parameter bit V_POL      = M640_V_POL,
  parameter int PIPE_DELAY = 2,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          blanking,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_err_cw
    $error("video_timing: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_err_sync
    $error("video_timing: sync widths must be non-zero");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_err_pipe
    $error("video_timing: PIPE_DELAY must be 0..15");
  end

  // Every boundary is at most H_TOTAL-1 / V_TOTAL-1, so all fit in CW bits.
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic flags_t decode(input logic [CW-1:0] xx, input logic [CW-1:0] yy);
    flags_t f;
    f.blank = (xx >= H_ACT_C) || (yy >= V_ACT_C);
    f.hs    = (xx >= HS_FIRST) && (xx <= HS_LAST);
    f.vs    = (yy >= VS_FIRST) && (yy <= VS_LAST);
    f.ls    = (xx == '0);
    f.fs    = (xx == '0) && (yy == '0);
    return f;
  endfunction

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  flags_t        flags_q;
  logic [4:0]    flags_dly;
  flags_t        flags_out;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ce) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // flags_q is decoded from the next-state counters, so it always describes the
  // position currently held in x_q/y_q. It resets to idle, which suppresses the
  // flags of the reset position itself (no frame_start until a full frame later).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      flags_q <= FLAGS_IDLE;
    end else if (ce) begin
      x_q     <= x_d;
      y_q     <= y_d;
      flags_q <= decode(x_d, y_d);
    end
  end

  delay_line #(
    .WIDTH     (5),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (FLAGS_IDLE)
  ) u_delay_line (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (flags_q),
    .q   (flags_dly)
  );

  assign flags_out   = flags_t'(flags_dly);
  assign x           = x_q;
  assign y           = y_q;
  // Polarity is a constant per build, so these stay glitch-free register outputs.
  assign h_sync      = flags_out.hs ? H_POL : ~H_POL;
  assign v_sync      = flags_out.vs ? V_POL : ~V_POL;
  assign blanking    = flags_out.blank;
  assign de          = ~flags_out.blank;
  assign line_start  = flags_out.ls;
  assign frame_start = flags_out.fs;

endmodule
